// File: rtl/fir_pkg.sv
// Shared width helpers for the parametrised FIR filter (fir_param_pipe).
// Build option FIR_SAT_EN (see fir_out_stage) does not affect anything here.
package fir_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Full-precision product width of one tap.
  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w;
  endfunction

  // Accumulator width: NTAPS products can never overflow it.
  function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + clog2(ntaps);
  endfunction

  // Coefficients are Q1.(COEF_W-1): drop the fractional bits on output.
  function automatic int frac_sh(input int coef_w);
    return coef_w - 1;
  endfunction

endpackage

// File: rtl/fir_out_stage.sv
// Output scaling: floor-shift of the accumulator, then wrap (default) or
// saturate to DATA_W when the FIR_SAT_EN macro is defined.
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int DATA_W  = 9,
  parameter int ACC_W   = acc_w(9, 9, 5),
  parameter int FRAC_SH = frac_sh(9)
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (DATA_W - 1)));

  logic signed [ACC_W-1:0] shifted;

  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    shifted = acc >>> FRAC_SH;
    if (shifted > SAT_HI)      y = DATA_W'(SAT_HI);
    else if (shifted < SAT_LO) y = DATA_W'(SAT_LO);
    else                       y = DATA_W'(shifted);
  end
`else
  assign y = DATA_W'(acc >>> FRAC_SH);
`endif

endmodule

// File: rtl/fir_param_pipe.sv
// Pipelined direct-form FIR: delay line -> product regs -> adder + out stage -> DOUT.
// Fixed 2-cycle latency; FIR_SAT_EN selects saturating instead of wrapping output.
module fir_param_pipe
  import fir_pkg::*;
#(
  parameter int NTAPS  = 5,
  parameter int DATA_W = 9,
  parameter int COEF_W = 9,
  localparam int AW    = clog2(NTAPS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic                     VIN,
  input  logic signed [DATA_W-1:0] DIN,
  input  logic                     COEF_WE,
  input  logic [AW-1:0]            COEF_ADDR,
  input  logic signed [COEF_W-1:0] COEF_DATA,
  output logic                     VOUT,
  output logic signed [DATA_W-1:0] DOUT
);

  localparam int PROD_W  = prod_w(DATA_W, COEF_W);
  localparam int ACC_W   = acc_w(DATA_W, COEF_W, NTAPS);
  localparam int FRAC_SH = frac_sh(COEF_W);

  logic signed [DATA_W-1:0] x [NTAPS];
  logic signed [COEF_W-1:0] b [NTAPS];
  logic signed [PROD_W-1:0] p [NTAPS];
  logic                     v0, v1;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] y;

  for (genvar i = 0; i < NTAPS; i++) begin : g_tap
    if (i == 0) begin : g_head
      always_ff @(posedge CLK) begin
        if (RST || CLR) x[i] <= '0;
        else if (VIN)   x[i] <= DIN;
      end
    end else begin : g_body
      always_ff @(posedge CLK) begin
        if (RST || CLR) x[i] <= '0;
        else if (VIN)   x[i] <= x[i-1];
      end
    end

    // NOTE: the coefficient bank is reset as well, so a fresh filter outputs zeros.
    // Addresses >= NTAPS match no tap and are therefore ignored.
    always_ff @(posedge CLK) begin
      if (RST)                                    b[i] <= '0;
      else if (COEF_WE && COEF_ADDR == AW'(i))   b[i] <= COEF_DATA;
    end

    always_ff @(posedge CLK) begin
      if (RST || CLR) p[i] <= '0;
      else            p[i] <= PROD_W'(x[i]) * PROD_W'(b[i]);
    end
  end

  // NOTE: blocking assignments are correct here: acc is a combinational running sum.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NTAPS; i++) acc = acc + ACC_W'(p[i]);
  end

  fir_out_stage #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .FRAC_SH(FRAC_SH)
  ) u_out_stage (
    .acc(acc),
    .y  (y)
  );

  // Valid pipe {v1,v0}; CLR kills in-flight samples but leaves DOUT untouched.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v0   <= 1'b0;
      v1   <= 1'b0;
      VOUT <= 1'b0;
      DOUT <= '0;
    end else if (CLR) begin
      v0   <= 1'b0;
      v1   <= 1'b0;
      VOUT <= 1'b0;
    end else begin
      v0   <= VIN;
      v1   <= v0;
      VOUT <= v1;
      if (v1) DOUT <= y;
    end
  end

endmodule

// File: tb/tb_fir_param_pipe.sv
// Scoreboard bench for fir_param_pipe (NTAPS=5, DATA_W=9, COEF_W=9), both FIR_SAT_EN builds.
module tb_fir_param_pipe;

  localparam int NTAPS = 5;

`ifdef FIR_SAT_EN
  localparam int T3_EXP = 255;
  localparam int T4_EXP = -256;
`else
  localparam int T3_EXP = 246;
  localparam int T4_EXP = -251;
`endif

  logic              CLK = 1'b0;
  logic              RST, CLR, VIN, COEF_WE;
  logic signed [8:0] DIN, COEF_DATA;
  logic [2:0]        COEF_ADDR;
  logic              VOUT;
  logic signed [8:0] DOUT;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t q[$];
  int   seen[$];
  int   m_line[NTAPS];
  int   m_b[NTAPS];
  int   last_dout;
  int   cyc;
  bit   started;
  int   n_pass, n_total;

  fir_param_pipe #(.NTAPS(5), .DATA_W(9), .COEF_W(9)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CLR      (CLR),
    .VIN      (VIN),
    .DIN      (DIN),
    .COEF_WE  (COEF_WE),
    .COEF_ADDR(COEF_ADDR),
    .COEF_DATA(COEF_DATA),
    .VOUT     (VOUT),
    .DOUT     (DOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: y = floor(sum(x[i]*b[i]) / 256), then saturate or wrap to 9 bits.
  function automatic int model_out();
    longint s;
    longint f;
    s = 0;
    for (int i = 0; i < NTAPS; i++) s += longint'(m_line[i]) * longint'(m_b[i]);
    f = s / 256;
    if ((s % 256) != 0 && s < 0) f = f - 1;
`ifdef FIR_SAT_EN
    if (f > 255)  f = 255;
    if (f < -256) f = -256;
`else
    f = f & 511;
    if (f >= 256) f = f - 512;
`endif
    return int'(f);
  endfunction

  // One clock: drive, update the model at the edge, return just after the falling edge.
  task automatic step(input bit rst, input bit clr, input bit vin, input int din,
                      input bit we, input int addr, input int cdata);
    RST = rst; CLR = clr; VIN = vin; DIN = 9'(din);
    COEF_WE = we; COEF_ADDR = 3'(addr); COEF_DATA = 9'(cdata);
    @(posedge CLK);
    cyc++;
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        m_line[i] = 0;
        m_b[i]    = 0;
      end
      q.delete();
      last_dout = 0;
    end else begin
      if (we && addr < NTAPS) m_b[addr] = cdata;
      if (clr) begin
        for (int i = 0; i < NTAPS; i++) m_line[i] = 0;
        q.delete();
      end else if (vin) begin
        for (int i = NTAPS - 1; i > 0; i--) m_line[i] = m_line[i-1];
        m_line[0] = din;
        q.push_back('{val: model_out(), due: cyc + 2});
      end
    end
    started = 1'b1;
    @(negedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic feed(input int d);
    step(0, 0, 1, d, 0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    step(0, 0, 0, 0, 1, a, d);
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    check({name, "_count"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++) check(name, seen[i], exp[i]);
  endtask

  // Monitor: pops the scoreboard whenever VOUT is seen, checks value and latency.
  always @(negedge CLK) begin
    if (started) begin
      if (VOUT) begin
        if (q.size() == 0) begin
          check("vout_extra", int'(VOUT), 0);
        end else begin
          check("dout", int'(DOUT), q[0].val);
          check("latency", cyc, q[0].due);
          last_dout = q[0].val;
          void'(q.pop_front());
        end
        seen.push_back(int'(DOUT));
      end else begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          check("vout_missing", int'(VOUT), 1);
          void'(q.pop_front());
        end
        check("dout_hold", int'(DOUT), last_dout);
      end
    end
  end

  initial begin
    int e[$];
    int r;
    n_pass = 0; n_total = 0; cyc = 0; started = 1'b0; last_dout = 0;
    for (int i = 0; i < NTAPS; i++) begin
      m_line[i] = 0;
      m_b[i]    = 0;
    end

    // 1. reset, zero coefficients give zero outputs
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    check("rst_vout", int'(VOUT), 0);
    check("rst_dout", int'(DOUT), 0);
    seen.delete();
    repeat (3) feed(100);
    idle(3);
    e = '{0, 0, 0};
    check_seq("t1_zero_coef", e);

    // 2. impulse response
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NTAPS; i++) wr(i, 10 * (i + 1));
    seen.delete();
    feed(128);
    repeat (5) feed(0);
    idle(3);
    e = '{5, 10, 15, 20, 25, 0};
    check_seq("t2_impulse", e);

    // 3. positive overload
    for (int i = 0; i < NTAPS; i++) wr(i, 255);
    seen.delete();
    repeat (8) feed(255);
    idle(3);
    check("t3_count", seen.size(), 8);
    for (int i = 4; i < 8 && i < seen.size(); i++) check("t3_pos_over", seen[i], T3_EXP);

    // 4. negative overload
    seen.delete();
    repeat (8) feed(-256);
    idle(3);
    check("t4_count", seen.size(), 8);
    for (int i = 4; i < 8 && i < seen.size(); i++) check("t4_neg_over", seen[i], T4_EXP);

    // 5. CLR mid-stream drops the same-cycle sample and both in flight
    for (int i = 0; i < NTAPS; i++) wr(i, 10 * (i + 1));
    step(0, 1, 0, 0, 0, 0, 0);
    seen.delete();
    feed(128);
    feed(0);
    feed(0);
    step(0, 1, 1, 77, 0, 0, 0);
    idle(2);
    feed(128);
    repeat (4) feed(0);
    idle(3);
    e = '{5, 5, 10, 15, 20, 25};
    check_seq("t5_clr", e);

    // 6. coefficient rewrite between samples, out-of-range address ignored
    step(0, 1, 0, 0, 0, 0, 0);
    seen.delete();
    feed(128);
    feed(0);
    wr(2, 0);
    wr(7, 99);
    repeat (3) feed(0);
    idle(3);
    e = '{5, 10, 0, 20, 25};
    check_seq("t6_coef_rw", e);

    // 7. reset during a burst
    for (int i = 0; i < 4; i++) feed(int'($urandom_range(0, 511)) - 256);
    step(1, 0, 1, 50, 0, 0, 0);
    check("t7_vout", int'(VOUT), 0);
    check("t7_dout", int'(DOUT), 0);
    idle(2);
    seen.delete();
    repeat (5) feed(100);
    idle(3);
    e = '{0, 0, 0, 0, 0};
    check_seq("t7_coef_zero", e);

    // Randomised traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      step(r < 2, r >= 2 && r < 6, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 511)) - 256, $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 511)) - 256);
    end
    idle(4);
    check("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
